led_bar_sequencer: RTL and testbench

//  Registered, parametrised LED bar driver for the stopwatch front panel; successor to the combinational seconds-to-LED mapper.

---
 rtl/led_bar_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_led_bar_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bar_sequencer.sv
`timescale 1ns/1ps
// led_bar_sequencer
//  Registered LED bar driver for the stopwatch front panel. Turns BCD seconds
//  (n1:n0) into a bar pattern that is mirrored about the centre of the bar, and
//  adds tick-driven chase, bounce and alarm-blink modes. Every output is
//  registered, so the LEDs follow the inputs one clock later.
//  Optional build macro: LED_FADE_EN adds a 2-bit free-running PWM counter.
//  In chase and bounce modes it shows the previously lit pair as a dim trail
//  at 25% duty.
module led_bar_sequencer #(
    parameter int NUM_LEDS = 16,
    parameter int STEP     = 5,
    parameter int SPAN     = 20,
    parameter int ALARM_AT = 55
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [1:0]          mode,
    input  logic [3:0]          n0,
    input  logic [3:0]          n1,
    output logic [NUM_LEDS-1:0] led,
    output logic                err
);

    localparam int PAIRS = NUM_LEDS / 2;
    localparam int PW    = $clog2(PAIRS);
    localparam logic [PW-1:0] LAST_POS = PW'(PAIRS - 1);
    localparam logic [PW-1:0] PEN_POS  = PW'(PAIRS - 2);

    localparam logic [1:0] MODE_BAR    = 2'd0;
    localparam logic [1:0] MODE_CHASE  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_ALARM  = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic [PW-1:0]       pos_reg, pos_next;
    logic                dir_reg, dir_next;
    logic                blink_reg, blink_next;
    logic [1:0]          mode_q_reg, mode_q_next;
    logic                err_reg, err_next;
    logic [NUM_LEDS-1:0] led_reg, led_next;
    logic [PAIRS-1:0]    bar_pairs, pos_pairs, sel_pairs;
    logic [NUM_LEDS-1:0] led_pat;
    logic [6:0]          n;
    int                  n_int;

`ifdef LED_FADE_EN
    logic [1:0]          pwm_reg;
    logic [PW-1:0]       prev_reg, prev_next;
    logic [PAIRS-1:0]    prev_pairs;
`endif

    // Binary seconds value. It is only meaningful when both digits are valid BCD.
    assign n     = ({3'd0, n1} * 7'd10) + {3'd0, n0};
    assign n_int = {25'd0, n};

    // Decode each pair's bar window and its position match.
    genvar gi;
    generate
        for (gi = 0; gi < PAIRS; gi++) begin : g_pair
            localparam int LO = (gi * STEP < 1) ? 1 : gi * STEP;
            localparam int HI = gi * STEP + SPAN + 1;
            assign bar_pairs[gi] = (n_int >= LO) && (n_int < HI);
            assign pos_pairs[gi] = (pos_next == PW'(gi));
`ifdef LED_FADE_EN
            assign prev_pairs[gi] = (prev_next == PW'(gi));
`endif
        end
    endgenerate

    // State register: async active-low reset clears everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_reg    <= '0;
            dir_reg    <= DIR_UP;
            blink_reg  <= 1'b0;
            mode_q_reg <= MODE_BAR;
            err_reg    <= 1'b0;
            led_reg    <= '0;
`ifdef LED_FADE_EN
            pwm_reg    <= 2'd0;
            prev_reg   <= '0;
`endif
        end else begin
            pos_reg    <= pos_next;
            dir_reg    <= dir_next;
            blink_reg  <= blink_next;
            mode_q_reg <= mode_q_next;
            err_reg    <= err_next;
            led_reg    <= led_next;
`ifdef LED_FADE_EN
            pwm_reg    <= pwm_reg + 2'd1;
            prev_reg   <= prev_next;
`endif
        end
    end

    // Next state: a mode change wins over (and swallows) a tick in the same cycle.
    always_comb begin
        pos_next    = pos_reg;
        dir_next    = dir_reg;
        blink_next  = blink_reg;
        mode_q_next = mode_q_reg;
`ifdef LED_FADE_EN
        prev_next   = prev_reg;
`endif
        if (mode != mode_q_reg) begin
            pos_next    = '0;
            dir_next    = DIR_UP;
            blink_next  = 1'b0;
            mode_q_next = mode;
`ifdef LED_FADE_EN
            prev_next   = '0;
`endif
        end else begin
            case (mode_q_reg)
                MODE_CHASE: begin
                    if (tick) begin
`ifdef LED_FADE_EN
                        prev_next = pos_reg;
`endif
                        pos_next = (pos_reg == LAST_POS) ? '0 : pos_reg + 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    if (tick) begin
`ifdef LED_FADE_EN
                        prev_next = pos_reg;
`endif
                        // Turn around on arrival so each end is shown for a single tick.
                        if (dir_reg == DIR_UP) begin
                            pos_next = pos_reg + 1'b1;
                            if (pos_reg == PEN_POS) dir_next = DIR_DOWN;
                        end else begin
                            pos_next = pos_reg - 1'b1;
                            if (pos_reg == PW'(1)) dir_next = DIR_UP;
                        end
                    end
                end
                MODE_ALARM: begin
                    if (n >= 7'(ALARM_AT)) begin
                        if (tick) blink_next = ~blink_reg;
                    end else begin
                        blink_next = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output pattern: choose the lit pairs for the current mode, mirror them, and hold them on invalid BCD.
    always_comb begin
        sel_pairs = '0;
        case (mode_q_next)
            MODE_BAR:    sel_pairs = bar_pairs;
            MODE_CHASE,
            MODE_BOUNCE: begin
                sel_pairs = pos_pairs;
`ifdef LED_FADE_EN
                if (pwm_reg == 2'd0) sel_pairs = sel_pairs | prev_pairs;
`endif
            end
            MODE_ALARM:  sel_pairs = {PAIRS{blink_next}};
            default:     sel_pairs = '0;
        endcase
        led_pat = '0;
        for (int i = 0; i < PAIRS; i++) begin
            led_pat[i]              = sel_pairs[i];
            led_pat[NUM_LEDS-1-i]   = sel_pairs[i];
        end
        err_next = (n0 > 4'd9) || (n1 > 4'd9);
        led_next = err_next ? led_reg : led_pat;
    end

    assign led = led_reg;
    assign err = err_reg;

endmodule

// File: tb/tb_led_bar_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for led_bar_sequencer. Stimulus pushes the expected LED and err values
// from a tick-count reference model. A monitor pops one entry per clock and compares it.
module tb_led_bar_sequencer;

    localparam int NUM_LEDS = 16;
    localparam int STEP     = 5;
    localparam int SPAN     = 20;
    localparam int ALARM_AT = 55;
    localparam int PAIRS    = NUM_LEDS / 2;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                tick = 1'b0;
    logic [1:0]          mode = 2'd0;
    logic [3:0]          n0 = 4'd0;
    logic [3:0]          n1 = 4'd0;
    logic [NUM_LEDS-1:0] led;
    logic                err;

    typedef struct {
        logic [NUM_LEDS-1:0] led;
        logic                err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;
    int   txn    = 0;

    // Reference model state. Pair position is derived from ticks counted since the mode was entered.
    int                  m_mode  = 0;
    int                  m_k     = 0;
    bit                  m_blink = 1'b0;
    logic [NUM_LEDS-1:0] m_led   = '0;
    bit                  m_err   = 1'b0;
    int                  m_edges = 0;

    led_bar_sequencer #(
        .NUM_LEDS(NUM_LEDS), .STEP(STEP), .SPAN(SPAN), .ALARM_AT(ALARM_AT)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .mode(mode),
        .n0(n0), .n1(n1), .led(led), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_LEDS-1:0] pair_mask(input int p);
        logic [NUM_LEDS-1:0] m;
        m = '0;
        m[p] = 1'b1;
        m[NUM_LEDS-1-p] = 1'b1;
        return m;
    endfunction

    function automatic logic [NUM_LEDS-1:0] bar_pattern(input int sec);
        logic [NUM_LEDS-1:0] m;
        int lo;
        m = '0;
        for (int p = 0; p < PAIRS; p++) begin
            lo = (p * STEP < 1) ? 1 : p * STEP;
            if (sec >= lo && sec < p * STEP + SPAN + 1) m = m | pair_mask(p);
        end
        return m;
    endfunction

    // Pair position after k ticks in chase (cyclic) or bounce (triangle wave) mode.
    function automatic int pos_of(input int md, input int k);
        int per, r;
        if (md == 1) return k % PAIRS;
        per = 2 * (PAIRS - 1);
        r = k % per;
        return (r <= PAIRS - 1) ? r : per - r;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_k = 0; m_blink = 1'b0; m_led = '0; m_err = 1'b0; m_edges = 0;
    endfunction

    // Apply inputs for the coming clock edge and queue the expected outputs after that edge.
    task automatic apply(input bit t, input int md, input int d0, input int d1);
        bit   inv;
        int   sec, pwm_now;
        exp_t e;
        tick = t; mode = 2'(md); n0 = 4'(d0); n1 = 4'(d1);
        inv = (d0 > 9) || (d1 > 9);
        sec = d1 * 10 + d0;
        pwm_now = m_edges % 4;
        m_edges++;
        if (md != m_mode) begin
            m_mode = md; m_k = 0; m_blink = 1'b0;
        end else if ((m_mode == 1 || m_mode == 2) && t) begin
            m_k++;
        end else if (m_mode == 3) begin
            if (sec >= ALARM_AT) begin
                if (t) m_blink = !m_blink;
            end else begin
                m_blink = 1'b0;
            end
        end
        if (!inv) begin
            case (m_mode)
                0: m_led = bar_pattern(sec);
                1, 2: begin
                    m_led = pair_mask(pos_of(m_mode, m_k));
`ifdef LED_FADE_EN
                    if (pwm_now == 0 && m_k > 0) m_led = m_led | pair_mask(pos_of(m_mode, m_k - 1));
`endif
                end
                default: m_led = m_blink ? '1 : '0;
            endcase
        end
        m_err = inv;
        e.led = m_led;
        e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit t, input int md, input int d0, input int d1);
        @(negedge clk);
        apply(t, md, d0, d1);
    endtask

    // Monitor: the DUT presents a new registered result every clock.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            txn++;
            checks++;
            if (led !== mon_e.led) begin
                fails++;
                $display("FAIL led txn %0d: got %h expected %h", txn, led, mon_e.led);
            end
            checks++;
            if (err !== mon_e.err) begin
                fails++;
                $display("FAIL err txn %0d: got %b expected %b", txn, err, mon_e.err);
            end
            $display("txn %0d mode=%0d tick=%b n=%h%h led=%h err=%b", txn, mode, tick, n1, n0, led, err);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int md, t, d0, d1;
        // Reset state, checked while reset is still held.
        #12;
        checks++;
        if (led !== '0) begin fails++; $display("FAIL reset_led: got %h expected 0", led); end
        checks++;
        if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        apply(0, 0, 0, 0);

        // Bar mode: sample values plus both ends of the range.
        drive(0, 0, 7, 0);
        drive(1, 0, 2, 2);
        drive(0, 0, 0, 0);
        drive(0, 0, 6, 5);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 2);
        drive(0, 0, 9, 9);

        // Chase: 9 ticks wrap past the last pair, with idle cycles in between.
        drive(0, 1, 3, 0);
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 3, 0);
            drive(0, 1, 3, 0);
        end

        // Mode change 1 -> 2 together with a tick, so the tick is discarded, then 16 bounce ticks.
        drive(1, 2, 3, 0);
        for (int i = 0; i < 16; i++) drive(1, 2, 3, 0);

        // Alarm: just below the threshold, at the threshold, then dropping back below it.
        drive(0, 3, 4, 5);
        for (int i = 0; i < 3; i++) drive(1, 3, 4, 5);
        for (int i = 0; i < 5; i++) drive(1, 3, 5, 5);
        drive(0, 3, 0, 5);
        drive(1, 3, 0, 5);
        drive(1, 3, 9, 5);

        // Invalid BCD: the LEDs freeze while the chase position keeps moving.
        drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        drive(1, 1, 10, 0);
        drive(1, 1, 10, 0);
        drive(0, 1, 2, 15);
        drive(0, 1, 2, 1);

        // Randomized traffic.
        md = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) md = $urandom_range(0, 3);
            t = $urandom_range(0, 1);
            d1 = (md == 3) ? $urandom_range(4, 5) : $urandom_range(0, 9);
            d0 = $urandom_range(0, 9);
            if (md != 3 && $urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 1) d0 = $urandom_range(10, 15);
                else d1 = $urandom_range(10, 15);
            end
            drive(t[0], md, d0, d1);
        end

        // Mid-run reset: chase at pos 3 with err set, then an asynchronous reset between clock edges.
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0);
        drive(0, 1, 11, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (led !== '0) begin fails++; $display("FAIL async_reset_led: got %h expected 0", led); end
        checks++;
        if (err !== 1'b0) begin fails++; $display("FAIL async_reset_err: got %b expected 0", err); end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        apply(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
